bidir_bus_arbiter: RTL

//  Sequences one shared tristate data bus between N requesters and the bus-side data register.

---
 rtl/bus_arb_pkg.sv | 35 +++
 rtl/rr_picker.sv | 38 +++
 rtl/bidir_bus_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module : bus_arb_pkg
// Brief  : Shared types and helpers for the bidirectional bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

  localparam int c_n_max = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  // One spare bit so the counter can hold BEATS-1 without wrapping.
  function automatic int beat_cnt_w(input int beats);
    return $clog2(beats) + 1;
  endfunction

  function automatic int onehot_idx(input logic [c_n_max-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < c_n_max; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin search; first request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  always_comb begin : p_pick
    int            k;
    logic [PW-1:0] slot;
    k     = 0;
    slot  = '0;
    win   = '0;
    valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      slot = PW'(k);
      if (!valid && req[slot]) begin
        win[slot] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bidir_bus_arbiter.sv
// ============================================================================
// Module : bidir_bus_arbiter
// Brief  : Round-robin owner sequencing of a shared tristate bus with a dead
//          turnaround cycle between owners. Optional macro BUS_LOCK_EN adds
//          a per-requester lock input that lets the owner keep the bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bidir_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int BEATS = 4
) (
  input  logic         CK,
  input  logic         CLR,
`ifdef BUS_LOCK_EN
  input  logic [N-1:0] lock,
`endif
  input  logic [N-1:0] req,
  input  logic [N-1:0] dir,
  output logic [N-1:0] gnt,
  output logic [N-1:0] drv_en,
  output logic         reg_oe,
  output logic         reg_we,
  output logic         busy
);

  localparam int c_pw = (N > 1) ? $clog2(N) : 1;
  localparam int c_cw = beat_cnt_w(BEATS);

  arb_state_t        r_state, w_state_n;
  logic [N-1:0]      r_win, w_win_n;
  logic              r_dirl, w_dirl_n;
  logic [c_pw-1:0]   r_ptr, w_ptr_n;
  logic [c_cw-1:0]   r_cnt, w_cnt_n;
`ifdef BUS_LOCK_EN
  logic              r_relock, w_relock_n;
`endif

  logic [N-1:0]      w_pick;
  logic              w_valid;
  logic [c_pw-1:0]   w_pick_idx;
  logic [c_pw-1:0]   w_ptr_adv;
  logic              w_pick_dir;
  logic              w_own_req;
  logic              w_active_n;
  logic [N-1:0]      w_gnt_n, w_drv_n;
  logic              w_oe_n, w_we_n;

  rr_picker #(
    .N  (N),
    .PW (c_pw)
  ) u_picker (
    .req   (req),
    .ptr   (r_ptr),
    .win   (w_pick),
    .valid (w_valid)
  );

  assign w_pick_idx = c_pw'(onehot_idx(c_n_max'(w_pick)));
  assign w_ptr_adv  = (w_pick_idx == c_pw'(N - 1)) ? '0 : w_pick_idx + 1'b1;
  assign w_pick_dir = |(dir & w_pick);
  assign w_own_req  = |(req & r_win);

  always_comb begin : p_next
    w_state_n  = r_state;
    w_win_n    = r_win;
    w_dirl_n   = r_dirl;
    w_ptr_n    = r_ptr;
    w_cnt_n    = r_cnt;
`ifdef BUS_LOCK_EN
    w_relock_n = r_relock;
`endif
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_n = SETUP;
          w_win_n   = w_pick;
          w_dirl_n  = w_pick_dir;
          w_ptr_n   = w_ptr_adv;
        end
      end
      SETUP: begin
        if (!w_own_req) begin
          w_state_n = TURN;
        end else begin
          w_state_n = XFER;
          w_cnt_n   = '0;
        end
      end
      XFER: begin
        if (!w_own_req || (r_cnt == c_cw'(BEATS - 1))) begin
          w_state_n  = TURN;
`ifdef BUS_LOCK_EN
          w_relock_n = |(lock & r_win);
`endif
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      TURN: begin
`ifdef BUS_LOCK_EN
        w_relock_n = 1'b0;
        if (r_relock && w_own_req) begin
          // Locked owner keeps the bus; pointer stays where it was.
          w_state_n = SETUP;
          w_dirl_n  = |(dir & r_win);
        end else
`endif
        if (w_valid) begin
          w_state_n = SETUP;
          w_win_n   = w_pick;
          w_dirl_n  = w_pick_dir;
          w_ptr_n   = w_ptr_adv;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    w_active_n = (w_state_n == SETUP) || (w_state_n == XFER);
    w_gnt_n    = w_active_n ? w_win_n : '0;
    w_drv_n    = (w_active_n && w_dirl_n) ? w_win_n : '0;
    w_oe_n     = w_active_n && !w_dirl_n;
    w_we_n     = (w_state_n == XFER) && w_dirl_n;
  end

  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      r_state  <= IDLE;
      r_win    <= '0;
      r_dirl   <= 1'b0;
      r_ptr    <= '0;
      r_cnt    <= '0;
`ifdef BUS_LOCK_EN
      r_relock <= 1'b0;
`endif
      gnt      <= '0;
      drv_en   <= '0;
      reg_oe   <= 1'b0;
      reg_we   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_win    <= w_win_n;
      r_dirl   <= w_dirl_n;
      r_ptr    <= w_ptr_n;
      r_cnt    <= w_cnt_n;
`ifdef BUS_LOCK_EN
      r_relock <= w_relock_n;
`endif
      gnt      <= w_gnt_n;
      drv_en   <= w_drv_n;
      reg_oe   <= w_oe_n;
      reg_we   <= w_we_n;
    end
  end

  assign busy = (r_state != IDLE);

endmodule

`default_nettype wire
